// File: rtl/ring_osc_ctrl.sv
// ring_osc_ctrl
//   Clocked sequencer and monitor for a self-timed NCL dual-rail ring. Holds
//   the ring in init, releases it on command, counts oscillations (rising
//   edges of one stage's COMP signal) and re-freezes the ring after the
//   programmed number of oscillations or when the ring stops toggling.
//
// Optional feature: define RING_OSC_PERIOD_EN to build the period monitor
//   (per_last / per_min / per_max / per_valid). Without it those ports read 0.
//
// Ports
//   clk        in   clock, rising edge
//   init_n     in   asynchronous active-low reset
//   start      in   launch a run (accepted in IDLE, DONE, STALL)
//   abort      in   return to IDLE from INIT or RUN
//   target     in   oscillations to run, latched with start
//   comp_mon   in   asynchronous COMP from one ring stage
//   ring_init  out  ring init net, high holds the ring in init
//   busy       out  high in INIT and RUN
//   done       out  high in DONE
//   stall      out  high in STALL
//   osc_count  out  oscillations counted in the current or last run
//   per_last   out  clocks between the last two counted oscillations
//   per_min    out  minimum period this run
//   per_max    out  maximum period this run
//   per_valid  out  period outputs meaningful (>=2 oscillations counted)
module ring_osc_ctrl #(
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned PER_W       = 12,
  parameter int unsigned INIT_CYCLES = 20,
  parameter int unsigned TIMEOUT     = 1023,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             init_n,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] target,
  input  logic             comp_mon,
  output logic             ring_init,
  output logic             busy,
  output logic             done,
  output logic             stall,
  output logic [CNT_W-1:0] osc_count,
  output logic [PER_W-1:0] per_last,
  output logic [PER_W-1:0] per_min,
  output logic [PER_W-1:0] per_max,
  output logic             per_valid
);

  localparam int unsigned IC_W  = $clog2(INIT_CYCLES + 1);
  localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);
  localparam logic [IC_W-1:0]  INIT_LOAD = IC_W'(INIT_CYCLES);
  localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT,
    S_RUN,
    S_DONE,
    S_STALL
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] target_q, target_d;
  logic [CNT_W-1:0] osc_q, osc_d;
  logic [IC_W-1:0]  icnt_q, icnt_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   comp_p_q;
  logic                   comp_s;
  logic                   comp_rise;
  logic                   comp_edge;

  // ---------------------------------------------------------------------
  // COMP synchronizer and edge detection (runs in every state)
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge init_n) begin
    if (!init_n) begin
      sync_q   <= '0;
      comp_p_q <= 1'b0;
    end else begin
      sync_q   <= {sync_q[SYNC_STAGES-2:0], comp_mon};
      comp_p_q <= comp_s;
    end
  end

  assign comp_s    = sync_q[SYNC_STAGES-1];
  assign comp_rise = comp_s & ~comp_p_q;
  assign comp_edge = comp_s ^ comp_p_q;

  // ---------------------------------------------------------------------
  // Sequencer
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge init_n) begin
    if (!init_n) begin
      state_q  <= S_IDLE;
      target_q <= '0;
      osc_q    <= '0;
      icnt_q   <= '0;
      tmo_q    <= '0;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
      osc_q    <= osc_d;
      icnt_q   <= icnt_d;
      tmo_q    <= tmo_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    osc_d    = osc_q;
    icnt_d   = icnt_q;
    tmo_d    = tmo_q;
    unique case (state_q)
      S_IDLE, S_DONE, S_STALL: begin
        if (start) begin
          target_d = target;
          osc_d    = '0;
          icnt_d   = INIT_LOAD;
          state_d  = S_INIT;
        end
      end
      S_INIT: begin
        if (abort) begin
          state_d = S_IDLE;
        end else begin
          icnt_d = icnt_q - 1'b1;
          if (icnt_q <= IC_W'(1)) begin
            tmo_d   = '0;
            state_d = (target_q == '0) ? S_DONE : S_RUN;
          end
        end
      end
      S_RUN: begin
        if (abort) begin
          state_d = S_IDLE;
        end else begin
          if (comp_rise && (osc_q != '1)) begin
            osc_d = osc_q + 1'b1;
          end
          tmo_d = comp_edge ? '0 : tmo_q + 1'b1;
          // Target check uses the freshly incremented count so DONE lands
          // on the same edge that counts the final oscillation.
          if (comp_rise && (osc_d == target_q)) begin
            state_d = S_DONE;
          end else if (!comp_edge && (tmo_q >= TMO_LAST)) begin
            state_d = S_STALL;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign ring_init = (state_q != S_RUN);
  assign busy      = (state_q == S_INIT) || (state_q == S_RUN);
  assign done      = (state_q == S_DONE);
  assign stall     = (state_q == S_STALL);
  assign osc_count = osc_q;

  // ---------------------------------------------------------------------
  // Period monitor
  // ---------------------------------------------------------------------
`ifdef RING_OSC_PERIOD_EN
  logic [PER_W-1:0] per_cnt_q, per_cnt_d;
  logic [PER_W-1:0] per_last_q, per_last_d;
  logic [PER_W-1:0] per_min_q, per_min_d;
  logic [PER_W-1:0] per_max_q, per_max_d;
  logic             per_valid_q, per_valid_d;
  logic             run_clear;
  logic             run_step;

  assign run_clear = start && ((state_q == S_IDLE) || (state_q == S_DONE) ||
                               (state_q == S_STALL));
  assign run_step  = (state_q == S_RUN) && !abort;

  always_ff @(posedge clk or negedge init_n) begin
    if (!init_n) begin
      per_cnt_q   <= '0;
      per_last_q  <= '0;
      per_min_q   <= '0;
      per_max_q   <= '0;
      per_valid_q <= 1'b0;
    end else begin
      per_cnt_q   <= per_cnt_d;
      per_last_q  <= per_last_d;
      per_min_q   <= per_min_d;
      per_max_q   <= per_max_d;
      per_valid_q <= per_valid_d;
    end
  end

  // The counter restarts at 1 on a rise so that, sampled at the next rise,
  // it holds exactly the number of clocks between the two rises.
  always_comb begin
    per_cnt_d   = per_cnt_q;
    per_last_d  = per_last_q;
    per_min_d   = per_min_q;
    per_max_d   = per_max_q;
    per_valid_d = per_valid_q;
    if (run_clear) begin
      per_cnt_d   = '0;
      per_last_d  = '0;
      per_min_d   = '0;
      per_max_d   = '0;
      per_valid_d = 1'b0;
    end else if (run_step) begin
      if (comp_rise) begin
        per_cnt_d = PER_W'(1);
        if (osc_q != '0) begin
          per_last_d  = per_cnt_q;
          per_valid_d = 1'b1;
          if (!per_valid_q) begin
            per_min_d = per_cnt_q;
            per_max_d = per_cnt_q;
          end else begin
            if (per_cnt_q < per_min_q) per_min_d = per_cnt_q;
            if (per_cnt_q > per_max_q) per_max_d = per_cnt_q;
          end
        end
      end else if (per_cnt_q != '1) begin
        per_cnt_d = per_cnt_q + 1'b1;
      end
    end
  end

  assign per_last  = per_last_q;
  assign per_min   = per_min_q;
  assign per_max   = per_max_q;
  assign per_valid = per_valid_q;
`else
  assign per_last  = '0;
  assign per_min   = '0;
  assign per_max   = '0;
  assign per_valid = 1'b0;
`endif

endmodule

// File: tb/tb_ring_osc_ctrl.sv
module tb_ring_osc_ctrl;

  logic        clk = 1'b0;
  logic        init_n;
  logic        start;
  logic        abort;
  logic [15:0] target;
  logic        comp_mon;
  logic        ring_init, busy, done, stall, per_valid;
  logic [15:0] osc_count;
  logic [11:0] per_last, per_min, per_max;

  // comp_mon is either a free-running square wave or driven by hand
  logic        wave_en = 1'b0;
  logic        wave_q  = 1'b0;
  int unsigned half    = 4;
  int unsigned ph      = 0;
  logic        man_comp = 1'b0;
  assign comp_mon = wave_en ? wave_q : man_comp;

  int n_total = 0;
  int n_pass  = 0;

  ring_osc_ctrl #(
    .CNT_W      (16),
    .PER_W      (12),
    .INIT_CYCLES(20),
    .TIMEOUT    (1023),
    .SYNC_STAGES(2)
  ) dut (
    .clk      (clk),
    .init_n   (init_n),
    .start    (start),
    .abort    (abort),
    .target   (target),
    .comp_mon (comp_mon),
    .ring_init(ring_init),
    .busy     (busy),
    .done     (done),
    .stall    (stall),
    .osc_count(osc_count),
    .per_last (per_last),
    .per_min  (per_min),
    .per_max  (per_max),
    .per_valid(per_valid)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (wave_en) begin
      if (ph + 1 >= half) begin
        wave_q = ~wave_q;
        ph     = 0;
      end else begin
        ph = ph + 1;
      end
    end else begin
      wave_q = 1'b0;
      ph     = 0;
    end
  end

  typedef struct {
    logic [15:0] tgt;
    int unsigned hp;        // half period in clocks, 0 = comp held low
    int          exp_init;  // clocks from start until INIT ends
    logic        exp_fell;  // ring_init dropped (entered RUN)
    int          exp_low;   // clocks spent in RUN, -1 = not checked
    logic        exp_done;
    logic        exp_stall;
    logic [15:0] exp_osc;
  } vec_t;

  vec_t vecs[5];

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic do_start(input logic [15:0] t);
    target = t;
    start  = 1'b1;
    tick(1);
    start  = 1'b0;
  endtask

  task automatic wait_fall();
    int k;
    k = 0;
    while (ring_init && k < 100) begin
      tick(1);
      k++;
    end
  endtask

  task automatic run_vec(input int idx);
    int n;
    int m;
    man_comp = 1'b0;
    half     = vecs[idx].hp;
    wave_en  = (vecs[idx].hp != 0);
    do_start(vecs[idx].tgt);
    n = 0;
    while (ring_init && busy && n < 100) begin
      tick(1);
      n++;
    end
    chk($sformatf("v%0d init_clks", idx), n, vecs[idx].exp_init);
    chk($sformatf("v%0d ring_init_fell", idx), {31'd0, ~ring_init}, {31'd0, vecs[idx].exp_fell});
    m = 0;
    while (busy && m < 5000) begin
      tick(1);
      m++;
    end
    if (vecs[idx].exp_low >= 0)
      chk($sformatf("v%0d run_clks", idx), m, vecs[idx].exp_low);
    chk($sformatf("v%0d busy", idx), {31'd0, busy}, 0);
    chk($sformatf("v%0d done", idx), {31'd0, done}, {31'd0, vecs[idx].exp_done});
    chk($sformatf("v%0d stall", idx), {31'd0, stall}, {31'd0, vecs[idx].exp_stall});
    chk($sformatf("v%0d osc_count", idx), {16'd0, osc_count}, {16'd0, vecs[idx].exp_osc});
    chk($sformatf("v%0d ring_init_end", idx), {31'd0, ring_init}, 1);
    wave_en = 1'b0;
    tick(2);
  endtask

  initial begin
    int k;
    logic [11:0] e_last, e_min, e_max;
    logic        e_valid;

    vecs[0] = '{tgt: 16'd5,   hp: 4, exp_init: 20, exp_fell: 1'b1, exp_low: -1,
                exp_done: 1'b1, exp_stall: 1'b0, exp_osc: 16'd5};
    vecs[1] = '{tgt: 16'd0,   hp: 4, exp_init: 20, exp_fell: 1'b0, exp_low: 0,
                exp_done: 1'b1, exp_stall: 1'b0, exp_osc: 16'd0};
    vecs[2] = '{tgt: 16'd100, hp: 0, exp_init: 20, exp_fell: 1'b1, exp_low: 1023,
                exp_done: 1'b0, exp_stall: 1'b1, exp_osc: 16'd0};
    vecs[3] = '{tgt: 16'd3,   hp: 2, exp_init: 20, exp_fell: 1'b1, exp_low: -1,
                exp_done: 1'b1, exp_stall: 1'b0, exp_osc: 16'd3};
    vecs[4] = '{tgt: 16'd1,   hp: 6, exp_init: 20, exp_fell: 1'b1, exp_low: -1,
                exp_done: 1'b1, exp_stall: 1'b0, exp_osc: 16'd1};

    init_n = 1'b0;
    start  = 1'b0;
    abort  = 1'b0;
    target = '0;
    #1;
    chk("rst ring_init", {31'd0, ring_init}, 1);
    chk("rst busy", {31'd0, busy}, 0);
    chk("rst done", {31'd0, done}, 0);
    chk("rst stall", {31'd0, stall}, 0);
    chk("rst osc_count", {16'd0, osc_count}, 0);
    chk("rst per_last", {20'd0, per_last}, 0);
    chk("rst per_min", {20'd0, per_min}, 0);
    chk("rst per_max", {20'd0, per_max}, 0);
    chk("rst per_valid", {31'd0, per_valid}, 0);
    tick(2);
    init_n = 1'b1;
    tick(2);

    for (int i = 0; i < 5; i++) run_vec(i);

    // abort after 3 oscillations, with a start pulse ignored during RUN
    half    = 4;
    wave_en = 1'b1;
    do_start(16'd100);
    wait_fall();
    k = 0;
    while (osc_count != 16'd2 && k < 200) begin
      tick(1);
      k++;
    end
    start = 1'b1;
    tick(1);
    start = 1'b0;
    chk("start_in_run busy", {31'd0, busy}, 1);
    chk("start_in_run ring_init", {31'd0, ring_init}, 0);
    chk("start_in_run osc_count", {16'd0, osc_count}, 2);
    k = 0;
    while (osc_count != 16'd3 && k < 200) begin
      tick(1);
      k++;
    end
    abort = 1'b1;
    tick(1);
    abort = 1'b0;
    chk("abort busy", {31'd0, busy}, 0);
    chk("abort ring_init", {31'd0, ring_init}, 1);
    chk("abort osc_count", {16'd0, osc_count}, 3);
    chk("abort done", {31'd0, done}, 0);
    chk("abort stall", {31'd0, stall}, 0);
    wave_en = 1'b0;
    tick(12);
    chk("after_abort osc_count", {16'd0, osc_count}, 3);

    // periods 8, 12, 6 over four counted rises
    man_comp = 1'b0;
    do_start(16'd4);
    wait_fall();
    man_comp = 1'b1; tick(4);
    man_comp = 1'b0; tick(4);
    man_comp = 1'b1; tick(6);
    man_comp = 1'b0; tick(6);
    man_comp = 1'b1; tick(3);
    man_comp = 1'b0; tick(3);
    man_comp = 1'b1;
    k = 0;
    while (busy && k < 50) begin
      tick(1);
      k++;
    end
`ifdef RING_OSC_PERIOD_EN
    e_last = 12'd6; e_min = 12'd6; e_max = 12'd12; e_valid = 1'b1;
`else
    e_last = 12'd0; e_min = 12'd0; e_max = 12'd0; e_valid = 1'b0;
`endif
    chk("per done", {31'd0, done}, 1);
    chk("per osc_count", {16'd0, osc_count}, 4);
    chk("per_last", {20'd0, per_last}, {20'd0, e_last});
    chk("per_min", {20'd0, per_min}, {20'd0, e_min});
    chk("per_max", {20'd0, per_max}, {20'd0, e_max});
    chk("per_valid", {31'd0, per_valid}, {31'd0, e_valid});
    man_comp = 1'b0;
    tick(4);

    // asynchronous reset mid-RUN, checked before the next clock edge
    half    = 4;
    wave_en = 1'b1;
    do_start(16'd100);
    wait_fall();
    tick(30);
    chk("pre_arst busy", {31'd0, busy}, 1);
    #3;
    init_n = 1'b0;
    #1;
    chk("arst ring_init", {31'd0, ring_init}, 1);
    chk("arst busy", {31'd0, busy}, 0);
    chk("arst done", {31'd0, done}, 0);
    chk("arst stall", {31'd0, stall}, 0);
    chk("arst osc_count", {16'd0, osc_count}, 0);
    chk("arst per_valid", {31'd0, per_valid}, 0);
    chk("arst per_last", {20'd0, per_last}, 0);
    #2;
    init_n  = 1'b1;
    wave_en = 1'b0;
    tick(3);
    chk("post_arst busy", {31'd0, busy}, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/ring_osc_ctrl.md
# ring_osc_ctrl

Clocked sequencer and monitor for a self-timed NCL dual-rail ring. It holds the ring in its init state and releases it on command. It counts ring oscillations by watching one stage's completion (COMP) signal, then freezes the ring again after a programmed number of oscillations or when the ring stops oscillating. It sits between a clocked test/control domain and a free-running dual-rail ring, driving that ring's active-high `init` net.

## Interface
Parameters:
- `CNT_W`, 16: width of the oscillation target and count.
- `PER_W`, 12: width of the period measurement registers.
- `INIT_CYCLES`, 20: number of clocks `ring_init` is held high in INIT (must be ≥1).
- `TIMEOUT`, 1023: clocks without a COMP edge in RUN before STALL is declared (must be ≥1).
- `SYNC_STAGES`, 2: synchronizer depth on `comp_mon` (must be ≥2).

Ports:
- `clk` in 1: clock; all state updates on the rising edge.
- `init_n` in 1: reset, asynchronous and active-low.
- `start` in 1: launch a run; sampled only in IDLE, DONE and STALL.
- `abort` in 1: return to IDLE from INIT or RUN.
- `target` in CNT_W: number of oscillations to run; sampled on the `start` edge.
- `comp_mon` in 1: asynchronous COMP from one ring stage.
- `ring_init` out 1: drives the ring's init net; high = ring held in init.
- `busy` out 1: high in INIT and RUN.
- `done` out 1: high in DONE.
- `stall` out 1: high in STALL.
- `osc_count` out CNT_W: oscillations counted in the current or last run.
- `per_last` out PER_W: clocks between the last two counted oscillations.
- `per_min` out PER_W: minimum period this run.
- `per_max` out PER_W: maximum period this run.
- `per_valid` out 1: period outputs are meaningful (at least 2 oscillations counted).

## Operation
- **Synchronizer and edge detection.** `comp_mon` passes through SYNC_STAGES flops to form `comp_s`. A registered copy `comp_p` is updated every cycle in every state. `rise = comp_s & ~comp_p` and `edge = comp_s ^ comp_p`.
- **Oscillation.** One oscillation is one `rise`, i.e. the completion of one DATA wavefront.
- **States:** IDLE, INIT, RUN, DONE, STALL.
- **Reset values:** state IDLE, `ring_init`=1, `busy`=`done`=`stall`=0, `osc_count`=0, all `per_*`=0, `per_valid`=0, and synchronizer flops 0.
- **IDLE / DONE / STALL:**
  - `ring_init`=1.
  - On `start`=1: latch `target`, clear `osc_count` and the `per_*` registers, load the init counter with INIT_CYCLES, go to INIT.
- **INIT:**
  - `ring_init`=1 and the init counter decrements.
  - When it reaches 0: if the latched target is 0, go to DONE; otherwise go to RUN and clear the timeout counter.
  - Edges seen in INIT are never counted.
- **RUN:**
  - `ring_init`=0.
  - On `rise`, `osc_count` increments. If the new value equals the target, go to DONE on that same edge.
  - On `edge`, the timeout counter clears; otherwise it increments. When it reaches TIMEOUT with no edge present, go to STALL.
- **Priority in RUN:** `abort` > target reached > timeout. A `rise` in the timeout cycle clears the timer, so no STALL occurs.
- **`abort`** in INIT or RUN returns to IDLE on the next edge and sets `ring_init`=1. `osc_count` holds its value. `abort` is ignored in other states.
- **`start` while `busy`** is ignored.
- **`osc_count`** saturates at 2^CNT_W−1. The target is never exceeded because DONE occurs first.

## Timing
- `ring_init` rises on the same clock edge that enters DONE, STALL or IDLE. It falls on the edge that enters RUN.
- From `start` sampled high, `ring_init` stays high for exactly INIT_CYCLES further clocks before falling.
- A `comp_mon` rising edge that meets setup is reflected in `osc_count` SYNC_STAGES+1 clock edges later.
- `done` and `stall` are registered state decodes, valid the edge after the state transition.
- Asynchronous `init_n` assertion mid-run forces reset values immediately. That includes `ring_init`=1, which freezes the ring.

## Configuration
- **`RING_OSC_PERIOD_EN` defined:**
  - A PER_W period counter runs in RUN, saturating at 2^PER_W−1, and restarts on each `rise`.
  - On every `rise` after the first, it is captured into `per_last`, and `per_min`/`per_max` update.
  - `per_valid` sets on the second counted `rise` and clears on `start`.
- **Not defined:** the period logic is absent. `per_last`, `per_min`, `per_max` and `per_valid` are tied to 0, and the ports remain.

## Test plan
- Reset, then `start` with `target`=5 and an 8-clock-period square wave on `comp_mon`: `ring_init` is high for 20 clocks then low, `osc_count` reaches 5, then `done`=1, `ring_init`=1 and `busy`=0.
- `start` with `target`=0: INIT lasts 20 clocks, then DONE with `osc_count`=0. `ring_init` never falls.
- `start` with `target`=100 and `comp_mon` held constant: STALL after TIMEOUT=1023 clocks in RUN, with `stall`=1, `ring_init`=1 and `osc_count`=0.
- Assert `abort` mid-RUN after 3 oscillations: IDLE, `osc_count`=3, `ring_init`=1. A `start` pulse during RUN has no effect.
- With `RING_OSC_PERIOD_EN`, feed periods of 8, 12 and 6 clocks: `per_min`=6, `per_max`=12, `per_last`=6, `per_valid`=1. Without the macro, all period outputs read 0.
- Pull `init_n` low mid-RUN: all outputs take reset values asynchronously, before the next `clk` edge.
